// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned LDR_STATE_WIDTH = 2;

    // Loader FSM states; encodings are fixed so debug readouts stay stable.
    typedef enum logic [LDR_STATE_WIDTH-1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a program image from a valid/ready word source into instruction
// memory port 0 and holds the core off until a complete image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned I_LENGTH = 1024,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              s_valid,
    input  logic [N-1:0]      s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wr_ena0,
    output logic [N-1:0]      addr0,
    output logic [N-1:0]      din0,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CW = ADDR_W + 1;
    // Index of the final memory word; a non-last beat here means overflow.
    localparam logic [ADDR_W:0] LAST_IDX = CW'(I_LENGTH - 1);

    ldr_state_e state_q, state_d;
    logic       accept;
    logic       clear_count;

    // Next-state decode, stream handshake and counter-clear strobe.
    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        accept      = 1'b0;
        clear_count = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    clear_count = 1'b1;
                end
            end
            StLoad: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid) begin
                    if (s_last) begin
                        state_d = StDone;
                    end else if (word_count == LAST_IDX) begin
                        state_d = StErr;
                    end
                end
            end
            StDone, StErr: begin
                if (start) begin
                    state_d     = StLoad;
                    clear_count = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, write-port register stage, word counter and flag decodes.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q    <= StIdle;
            wr_ena0    <= 1'b0;
            addr0      <= '0;
            din0       <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            core_hold  <= 1'b1;
        end else begin
            state_q <= state_d;
            wr_ena0 <= accept;
            if (accept) begin
                addr0 <= {{(N-ADDR_W){1'b0}}, word_count[ADDR_W-1:0]};
                din0  <= s_data;
            end
            // Counter stops at I_LENGTH because LOAD is left on that beat.
            if (clear_count) begin
                word_count <= '0;
            end else if (accept) begin
                word_count <= word_count + 1'b1;
            end
            busy      <= (state_d == StLoad);
            done      <= (state_d == StDone);
            overflow  <= (state_d == StErr);
            core_hold <= (state_d != StDone);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a full-size instance for the
// normal flows and a 4-word instance for the overflow path.
module tb_imem_loader;

    logic        clk;
    logic        rstb;

    // Full-size instance signals.
    logic        start, s_valid, s_last;
    logic [31:0] s_data;
    logic        s_ready, wr_ena0, core_hold, busy, done, overflow;
    logic [31:0] addr0, din0;
    logic [10:0] word_count;

    // 4-word instance signals.
    logic        t_start, t_valid, t_last;
    logic [31:0] t_data;
    logic        t_ready, t_wr, t_hold, t_busy, t_done, t_ovf;
    logic [31:0] t_addr, t_din;
    logic [2:0]  t_count;

    int n_cmp;
    int n_bad;
    int t_writes;
    int t_high_writes;

    logic [31:0] mem [0:7];

    imem_loader #(.N(32), .I_LENGTH(1024), .ADDR_W(10)) u_dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .wr_ena0    (wr_ena0),
        .addr0      (addr0),
        .din0       (din0),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    imem_loader #(.N(32), .I_LENGTH(4), .ADDR_W(2)) u_small (
        .clk        (clk),
        .rstb       (rstb),
        .start      (t_start),
        .s_valid    (t_valid),
        .s_data     (t_data),
        .s_last     (t_last),
        .s_ready    (t_ready),
        .wr_ena0    (t_wr),
        .addr0      (t_addr),
        .din0       (t_din),
        .core_hold  (t_hold),
        .busy       (t_busy),
        .done       (t_done),
        .overflow   (t_ovf),
        .word_count (t_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for the full-size instance (only low indices are exercised).
    always @(posedge clk) begin
        if (wr_ena0) begin
            mem[addr0[2:0]] <= din0;
        end
    end

    // Write tally for the small instance, including any write past its depth.
    always @(posedge clk) begin
        if (t_wr) begin
            t_writes <= t_writes + 1;
            if (t_addr >= 32'd4) begin
                t_high_writes <= t_high_writes + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set after this return are seen on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t_writes = 0;
        t_high_writes = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        rstb = 1'b1;
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0;
        t_start = 1'b0; t_valid = 1'b0; t_last = 1'b0; t_data = 32'h0;

        // Reset then idle.
        tick();
        tick();
        check_eq("rst_hold", core_hold, 1);
        check_eq("rst_ready", s_ready, 0);
        check_eq("rst_wr", wr_ena0, 0);
        check_eq("rst_count", word_count, 0);
        check_eq("rst_flags", {busy, done, overflow}, 3'b000);
        rstb = 1'b0;
        tick();
        tick();
        check_eq("idle_wr", wr_ena0, 0);
        check_eq("idle_hold", core_hold, 1);
        check_eq("idle_ready", s_ready, 0);

        // Basic three-word load.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("load_busy", busy, 1);
        check_eq("load_ready", s_ready, 1);
        check_eq("load_hold", core_hold, 1);
        s_valid = 1'b1; s_data = 32'h00500093;
        tick();
        check_eq("b0_wr", wr_ena0, 1);
        check_eq("b0_addr", addr0, 0);
        check_eq("b0_din", din0, 32'h00500093);
        s_data = 32'h00A00113;
        tick();
        check_eq("b1_wr", wr_ena0, 1);
        check_eq("b1_addr", addr0, 1);
        check_eq("b1_din", din0, 32'h00A00113);
        s_data = 32'h002081B3; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check_eq("b2_wr", wr_ena0, 1);
        check_eq("b2_addr", addr0, 2);
        check_eq("b2_din", din0, 32'h002081B3);
        check_eq("b_done", done, 1);
        check_eq("b_hold", core_hold, 0);
        check_eq("b_busy", busy, 0);
        check_eq("b_count", word_count, 3);
        check_eq("b_ready", s_ready, 0);
        tick();
        check_eq("b_wr_off", wr_ena0, 0);
        check_eq("b_mem0", mem[0], 32'h00500093);
        check_eq("b_mem1", mem[1], 32'h00A00113);
        check_eq("b_mem2", mem[2], 32'h002081B3);

        // Reload from DONE with a one-word image.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("r_hold", core_hold, 1);
        check_eq("r_busy", busy, 1);
        check_eq("r_count0", word_count, 0);
        s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check_eq("r_wr", wr_ena0, 1);
        check_eq("r_addr", addr0, 0);
        check_eq("r_done", done, 1);
        check_eq("r_count", word_count, 1);
        check_eq("r_hold_off", core_hold, 0);
        tick();
        check_eq("r_mem0", mem[0], 32'hDEADBEEF);
        check_eq("r_mem1", mem[1], 32'h00A00113);
        check_eq("r_mem2", mem[2], 32'h002081B3);

        // Stalled stream: valid 1,0,0,1(last).
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 32'h11;
        tick();
        check_eq("s0_wr", wr_ena0, 1);
        check_eq("s0_addr", addr0, 0);
        check_eq("s0_din", din0, 32'h11);
        s_valid = 1'b0; s_data = 32'hFF;
        tick();
        check_eq("s_gap1_wr", wr_ena0, 0);
        check_eq("s_gap_busy", busy, 1);
        tick();
        check_eq("s_gap2_wr", wr_ena0, 0);
        check_eq("s_gap_count", word_count, 1);
        s_valid = 1'b1; s_data = 32'h22; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check_eq("s1_wr", wr_ena0, 1);
        check_eq("s1_addr", addr0, 1);
        check_eq("s1_din", din0, 32'h22);
        check_eq("s_done", done, 1);
        check_eq("s_count", word_count, 2);

        // Reset during the third beat of a load.
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 32'h33;
        tick();
        s_data = 32'h44;
        tick();
        check_eq("m1_addr", addr0, 1);
        s_data = 32'h55; rstb = 1'b1;
        tick();
        rstb = 1'b0; s_valid = 1'b0;
        check_eq("m_wr", wr_ena0, 0);
        check_eq("m_hold", core_hold, 1);
        check_eq("m_count", word_count, 0);
        check_eq("m_busy", busy, 0);
        check_eq("m_ready", s_ready, 0);
        tick();
        check_eq("m_mem0", mem[0], 32'h33);
        check_eq("m_mem1", mem[1], 32'h44);
        check_eq("m_mem2", mem[2], 32'h002081B3);

        // Start coinciding with reset: reset wins.
        start = 1'b1; rstb = 1'b1;
        tick();
        start = 1'b0; rstb = 1'b0;
        check_eq("sr_busy", busy, 0);
        check_eq("sr_ready", s_ready, 0);

        // Overflow on the 4-word instance: five beats, none marked last.
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        t_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t_data = 32'hA0 + k;
            tick();
            check_eq("o_wr", t_wr, 1);
            check_eq("o_addr", t_addr, k);
            check_eq("o_din", t_din, 32'hA0 + k);
        end
        check_eq("o_ready", t_ready, 0);
        check_eq("o_ovf", t_ovf, 1);
        check_eq("o_hold", t_hold, 1);
        check_eq("o_count", t_count, 4);
        t_data = 32'hA4;
        tick();
        t_valid = 1'b0;
        check_eq("o5_wr", t_wr, 0);
        check_eq("o5_count", t_count, 4);
        check_eq("o_writes", t_writes, 4);
        check_eq("o_high", t_high_writes, 0);
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check_eq("o_restart_ovf", t_ovf, 0);
        check_eq("o_restart_busy", t_busy, 1);
        check_eq("o_restart_count", t_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
